// File: rtl/addsub_accumulator.sv
// Sequential operand stage: accumulates NUM_OPS add/sub operands over a valid/ready
// handshake and presents the final value with a sticky carry/borrow flag.
module addsub_accumulator #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ACC_WIDTH = 8,
    parameter int unsigned NUM_OPS   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] acc,
    output logic                 ovf,
    output logic                 busy
);

    localparam int unsigned CNT_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_OPS - 1);

    logic [1:0]           state, state_nxt;
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [ACC_WIDTH-1:0] acc_nxt;
    logic                 ovf_nxt;
    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH:0]   sum;
    logic                 borrow;
    logic                 xfer;

    // Datapath: zero-extended operand, carry from the widened sum, borrow by compare
    assign ext    = ACC_WIDTH'(in_data);
    assign sum    = {1'b0, acc} + {1'b0, ext};
    assign borrow = (acc < ext);
    assign xfer   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        ovf_nxt   = ovf;
        cnt_nxt   = cnt;
        if (clear) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            ovf_nxt   = 1'b0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = ACCUM;
                        acc_nxt   = '0;
                        ovf_nxt   = 1'b0;
                        cnt_nxt   = '0;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        if (in_sub) begin
                            acc_nxt = acc - ext;
                            ovf_nxt = ovf | borrow;
                        end else begin
                            acc_nxt = sum[ACC_WIDTH-1:0];
                            ovf_nxt = ovf | sum[ACC_WIDTH];
                        end
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == LAST) begin
                            state_nxt = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Handshake/status flags are registered from the next state so they track it exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            acc       <= acc_nxt;
            ovf       <= ovf_nxt;
            in_ready  <= (state_nxt == ACCUM);
            out_valid <= (state_nxt == DONE);
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_addsub_accumulator.sv
// Scoreboard bench for addsub_accumulator: default 8-bit/4-op instance plus a
// 5-bit/3-op instance for carry-out coverage.
module tb_addsub_accumulator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0, start5 = 1'b0, clear = 1'b0;
    logic       in_valid = 1'b0, in_sub = 1'b0, out_ready = 1'b0;
    logic [3:0] in_data = 4'd0;

    logic       in_ready, out_valid, ovf, busy;
    logic [7:0] acc;
    logic       in_ready5, out_valid5, ovf5, busy5;
    logic [4:0] acc5;

    typedef struct {
        logic [7:0] acc;
        logic       ovf;
    } exp_t;

    exp_t q8[$];
    exp_t q5[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    addsub_accumulator u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .acc(acc), .ovf(ovf), .busy(busy)
    );

    addsub_accumulator #(.WIDTH(4), .ACC_WIDTH(5), .NUM_OPS(3)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready5), .in_data(in_data), .in_sub(in_sub),
        .out_valid(out_valid5), .out_ready(out_ready), .acc(acc5), .ovf(ovf5), .busy(busy5)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors pop an expected result whenever a result handshake completes
    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q8.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb8_unexpected: got acc %0h with nothing expected", acc);
            end else begin
                e = q8.pop_front();
                chk("sb8_acc", 32'(acc), 32'(e.acc));
                chk("sb8_ovf", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin : mon5
        exp_t e;
        if (rst_n && out_valid5 && out_ready) begin
            if (q5.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb5_unexpected: got acc %0h with nothing expected", acc5);
            end else begin
                e = q5.pop_front();
                chk("sb5_acc", 32'(acc5), 32'(e.acc));
                chk("sb5_ovf", 32'(ovf5), 32'(e.ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic is5);
        if (is5) start5 = 1'b1; else start = 1'b1;
        tick();
        start  = 1'b0;
        start5 = 1'b0;
    endtask

    task automatic send(input logic [3:0] d, input logic s, input int gap, input logic is5);
        int k = 0;
        in_data  = d;
        in_sub   = s;
        in_valid = 1'b1;
        while (!(is5 ? in_ready5 : in_ready) && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL in_ready_timeout: got in_ready 0 expected 1 within 20 cycles");
        end
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic take_result(input logic is5);
        int k = 0;
        while (!(is5 ? out_valid5 : out_valid) && k < 20) begin
            tick();
            k++;
        end
        if (k >= 20) begin
            n_cmp++;
            n_err++;
            $display("FAIL out_valid_timeout: got out_valid 0 expected 1 within 20 cycles");
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(is5 ? out_valid5 : out_valid), 32'd0);
        chk("busy_drop", 32'(is5 ? busy5 : busy), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held with random inputs
        #1 rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start    = 1'($urandom);
            clear    = 1'($urandom);
            in_valid = 1'($urandom);
            in_sub   = 1'($urandom);
            in_data  = 4'($urandom);
            out_ready = 1'($urandom);
            tick();
            chk("rst_acc", 32'(acc), 32'd0);
            chk("rst_ovf", 32'(ovf), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
        end
        start = 1'b0; clear = 1'b0; in_valid = 1'b0; in_sub = 1'b0;
        in_data = 4'd0; out_ready = 1'b0;
        rst_n = 1'b1;
        tick();

        // Asynchronous reset mid-run
        pulse_start(1'b0);
        chk("accum_busy", 32'(busy), 32'd1);
        send(4'd3, 1'b0, 0, 1'b0);
        chk("pre_rst_acc", 32'(acc), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_acc", 32'(acc), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic run: +9 +10 -3 +1
        pulse_start(1'b0);
        send(4'd9, 1'b0, 0, 1'b0);  chk("t2_acc1", 32'(acc), 32'd9);
        send(4'd10, 1'b0, 0, 1'b0); chk("t2_acc2", 32'(acc), 32'd19);
        send(4'd3, 1'b1, 0, 1'b0);  chk("t2_acc3", 32'(acc), 32'd16);
        send(4'd1, 1'b0, 0, 1'b0);  chk("t2_acc4", 32'(acc), 32'h11);
        chk("t2_out_valid", 32'(out_valid), 32'd1);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        q8.push_back('{acc: 8'h11, ovf: 1'b0});
        take_result(1'b0);
        chk("t2_idle_hold", 32'(acc), 32'h11);

        // Borrow: +2 -12 +0 +0
        pulse_start(1'b0);
        chk("t3_start_clr", 32'(acc), 32'd0);
        send(4'd2, 1'b0, 0, 1'b0);
        send(4'd12, 1'b1, 0, 1'b0); chk("t3_ovf2", 32'(ovf), 32'd1);
        send(4'd0, 1'b0, 0, 1'b0);
        send(4'd0, 1'b0, 0, 1'b0);
        q8.push_back('{acc: 8'hF6, ovf: 1'b1});
        take_result(1'b0);

        // Carry on the 5-bit / 3-op instance: 15, 30, 13
        pulse_start(1'b1);
        send(4'd15, 1'b0, 0, 1'b1); chk("t4_acc1", 32'(acc5), 32'd15); chk("t4_ovf1", 32'(ovf5), 32'd0);
        send(4'd15, 1'b0, 0, 1'b1); chk("t4_acc2", 32'(acc5), 32'd30); chk("t4_ovf2", 32'(ovf5), 32'd0);
        send(4'd15, 1'b0, 0, 1'b1); chk("t4_acc3", 32'(acc5), 32'd13); chk("t4_ovf3", 32'(ovf5), 32'd1);
        chk("t4_other_idle", 32'(busy), 32'd0);
        q5.push_back('{acc: 8'd13, ovf: 1'b1});
        take_result(1'b1);

        // Gapped operands, then extra operands and start pulses while DONE is stalled
        pulse_start(1'b0);
        send(4'd1, 1'b0, 2, 1'b0);
        send(4'd2, 1'b0, 2, 1'b0);
        send(4'd3, 1'b0, 2, 1'b0);
        send(4'd4, 1'b0, 0, 1'b0);
        in_valid = 1'b1;
        in_data  = 4'd7;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            tick();
            chk("t5_out_valid_hold", 32'(out_valid), 32'd1);
            chk("t5_acc_hold", 32'(acc), 32'd10);
            chk("t5_in_ready_low", 32'(in_ready), 32'd0);
        end
        start = 1'b0;
        q8.push_back('{acc: 8'd10, ovf: 1'b0});
        take_result(1'b0);
        tick();
        in_valid = 1'b0;
        chk("t5_idle_acc", 32'(acc), 32'd10);

        // Clear beats a simultaneous transfer
        pulse_start(1'b0);
        send(4'd5, 1'b0, 0, 1'b0);
        send(4'd6, 1'b0, 0, 1'b0);
        chk("t6_acc2", 32'(acc), 32'd11);
        in_data  = 4'd9;
        in_valid = 1'b1;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("t6_clr_acc", 32'(acc), 32'd0);
        chk("t6_clr_in_ready", 32'(in_ready), 32'd0);
        chk("t6_clr_busy", 32'(busy), 32'd0);
        pulse_start(1'b0);
        for (int i = 0; i < 4; i++) send(4'd1, 1'b0, 0, 1'b0);
        chk("t6_acc", 32'(acc), 32'd4);
        q8.push_back('{acc: 8'd4, ovf: 1'b0});
        take_result(1'b0);

        tick();
        chk("sb_drained", 32'(q8.size() + q5.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/addsub_accumulator.md
Name: addsub_accumulator

Overview:
Sequential operand stage wrapped around the 4-bit add/subtract datapath. It accepts a stream of NUM_OPS operands over a valid/ready handshake, each tagged add or subtract. It keeps a running ACC_WIDTH-bit result and presents the final value plus a sticky overflow/borrow flag on an output handshake. It sits between the lab's operand source (switches or stimulus FSM) and the result display stage.

Parameters:
WIDTH, 4, operand width (matches the add/sub datapath operand width)
ACC_WIDTH, 8, accumulator width; must be >= WIDTH+1
NUM_OPS, 4, operands accepted per run (1..255)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins a run (honoured in IDLE only)
clear  input  1  synchronous abort; returns to IDLE from any state
in_valid  input  1  operand present
in_ready  output  1  block can take an operand
in_data  input  WIDTH  unsigned operand
in_sub  input  1  1 = subtract in_data, 0 = add (same encoding as the S select)
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
acc  output  ACC_WIDTH  running/final accumulator value
ovf  output  1  sticky carry-out (add) or borrow (sub) seen during this run
busy  output  1  high in ACCUM or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, acc=0, ovf=0, op counter=0, in_ready=0, out_valid=0, busy=0. All outputs are registered and reach these values immediately, without waiting for a clock edge.
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=0, out_valid=0. start=1 at an edge: acc<=0, ovf<=0, cnt<=0, go to ACCUM. In IDLE, acc and ovf keep the previous run's values.
- ACCUM: in_ready=1. A transfer happens when in_valid && in_ready at a rising edge, and updates acc on that same edge (0-cycle latency after the handshake).
- Arithmetic: the operand is zero-extended to ACC_WIDTH.
  - Add: {c, acc} <= acc + ext.
  - Sub: acc <= acc - ext (two's complement, wraps mod 2^ACC_WIDTH), with borrow = (acc < ext).
  - ovf <= ovf | c (add) or ovf | borrow (sub). ovf never clears within a run.
- cnt increments on every transfer. The transfer with cnt == NUM_OPS-1 moves the state to DONE on that edge, and in_ready drops in the next cycle.
- in_valid low in ACCUM: no change. Gaps of any length are legal.
- DONE: out_valid=1, in_ready=0. acc and ovf are held stable. out_valid && out_ready at an edge: go to IDLE (out_valid=0 next cycle). out_valid may stay asserted indefinitely.
- start outside IDLE is ignored.
- clear has priority over start and over any transfer on the same edge: state<=IDLE, acc<=0, ovf<=0, cnt<=0.
- Reset mid-run has the same effect as clear, but asynchronous. After rst_n rises, the first start behaves normally.
- in_data and in_sub are sampled only on a transfer edge.

Test Plan:
1. Hold rst_n=0 for 3 cycles with random inputs -> acc=0, ovf=0, in_ready=0, out_valid=0, busy=0. Drop rst_n mid-cycle while in ACCUM -> outputs go to reset values before the next edge.
2. start; transfers +9, +10, -3, +1 (ACC_WIDTH=8) -> acc 9, 19, 16, 17 on successive transfer edges. out_valid=1 the cycle after the 4th transfer, acc=8'h11, ovf=0. out_ready=1 -> IDLE next cycle.
3. start; +2, -12, +0, +0 -> acc=8'hF6, ovf=1 (borrow on the 2nd op, stays set through ops 3-4).
4. Carry check with ACC_WIDTH=5, NUM_OPS=3: +15, +15, +15 -> acc 15, 30, 13. ovf=1 set on the 3rd edge.
5. Handshake stress: in_valid toggled with 2-cycle gaps, and in_valid held high in DONE -> exactly NUM_OPS transfers counted, extra operands are not consumed. out_ready held low 5 cycles -> out_valid and acc stay stable, start pulses in DONE are ignored.
6. clear asserted together with in_valid after 2 transfers -> IDLE next cycle, acc=0, that operand is not added. A following start and 4 ops of +1 -> acc=4, ovf=0.
